// File: rtl/afe_capture_if.sv
// Pixel output stream: FWFT data with last flag and downstream ready.
interface afe_capture_if;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_last;
   logic        pix_ready;

   modport master (output pix_data, pix_valid, pix_last, input pix_ready);
   modport slave  (input pix_data, pix_valid, pix_last, output pix_ready);
endinterface

// File: rtl/afe_capture.sv
// AFE line capture: samples the 8-bit DDR-style AFE bus on delayed adcclk
// edges, discards the ADC pipeline fill, and streams one line of 16-bit
// pixels through a 4-deep first-word-fall-through FIFO.
module afe_capture #(
   parameter int PIXELS     = 2592,
   parameter int PIPE_LAT   = 3,
   parameter int SAMPLE_DLY = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          adcclk,
   input  logic [7:0]    adc_data,
   input  logic          line_start,
   afe_capture_if.master pix,
   output logic          busy,
   output logic          overflow
);

   typedef enum logic [1:0] {IDLE, FLUSH, CAPTURE} state_t;

   localparam logic [4:0]  DLY    = 5'(SAMPLE_DLY);
   localparam logic [11:0] PIX_M1 = 12'(PIXELS - 1);
   localparam logic [11:0] LAT_M1 = 12'(PIPE_LAT - 1);

   logic        r_adcclk_d;
   logic [4:0]  r_dly;
   logic        r_dly_rise;
   logic [7:0]  r_hi;
   logic        r_hi_vld;
   state_t      r_state;
   logic [11:0] r_flush_cnt;
   logic [11:0] r_pix_cnt;
   logic [16:0] r_mem [4];
   logic [1:0]  r_wp;
   logic [1:0]  r_rp;
   logic [2:0]  r_cnt;
   logic        r_ovf;

   logic w_rise, w_fall, w_stb, w_stb_hi, w_stb_lo, w_done;
   logic w_push, w_last, w_pop, w_full, w_wr, w_valid;

   assign w_rise   = adcclk & ~r_adcclk_d;
   assign w_fall   = ~adcclk & r_adcclk_d;
   assign w_stb    = (r_dly == 5'd1);
   assign w_stb_hi = w_stb & r_dly_rise;
   assign w_stb_lo = w_stb & ~r_dly_rise;
   // A sample only completes if its high byte was seen in this line.
   assign w_done   = w_stb_lo & r_hi_vld;
   // A restart on the completing cycle discards the sample.
   assign w_push   = (r_state == CAPTURE) & w_done & ~line_start;
   assign w_last   = (r_pix_cnt == PIX_M1);
   assign w_valid  = (r_cnt != 3'd0);
   assign w_pop    = w_valid & pix.pix_ready;
   assign w_full   = (r_cnt == 3'd4);
   // At full, a same-cycle pop frees the slot being written.
   assign w_wr     = w_push & (~w_full | w_pop);

   assign pix.pix_valid = w_valid;
   assign pix.pix_data  = w_valid ? r_mem[r_rp][15:0] : 16'h0000;
   assign pix.pix_last  = w_valid & r_mem[r_rp][16];
   assign busy          = (r_state != IDLE);
   assign overflow      = r_ovf;

   // Edge detect and per-edge delay counter; free-running in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_adcclk_d <= 1'b0;
         r_dly      <= '0;
         r_dly_rise <= 1'b0;
      end else begin
         r_adcclk_d <= adcclk;
         if (w_rise | w_fall) begin
            r_dly      <= DLY;
            r_dly_rise <= w_rise;
         end else if (r_dly != 5'd0) begin
            r_dly <= r_dly - 5'd1;
         end
      end
   end

   // High-byte latch; validity is dropped at line start and once consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi     <= '0;
         r_hi_vld <= 1'b0;
      end else if (line_start) begin
         r_hi_vld <= 1'b0;
      end else if (w_stb_hi) begin
         r_hi     <= adc_data;
         r_hi_vld <= 1'b1;
      end else if (w_stb_lo) begin
         r_hi_vld <= 1'b0;
      end
   end

   // Line FSM: discard pipeline fill, then count PIXELS samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_flush_cnt <= '0;
         r_pix_cnt   <= '0;
      end else if (line_start) begin
         r_state     <= (PIPE_LAT == 0) ? CAPTURE : FLUSH;
         r_flush_cnt <= '0;
         r_pix_cnt   <= '0;
      end else begin
         case (r_state)
            FLUSH: if (w_done) begin
               r_flush_cnt <= r_flush_cnt + 12'd1;
               if (r_flush_cnt == LAT_M1) r_state <= CAPTURE;
            end
            CAPTURE: if (w_done) begin
               // Counts even when the FIFO drops the sample.
               r_pix_cnt <= r_pix_cnt + 12'd1;
               if (w_last) r_state <= IDLE;
            end
            default: ;
         endcase
      end
   end

   // Output FIFO with sticky overflow on a dropped write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) r_mem[i] <= '0;
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_wr) begin
            r_mem[r_wp] <= {w_last, r_hi, adc_data};
            r_wp        <= r_wp + 2'd1;
         end
         if (w_pop) r_rp <= r_rp + 2'd1;
         case ({w_wr, w_pop})
            2'b10:   r_cnt <= r_cnt + 3'd1;
            2'b01:   r_cnt <= r_cnt - 3'd1;
            default: ;
         endcase
         if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_afe_capture.sv
// Bench for afe_capture: three instances (4/3, 6/3, 1/0 pixels/latency)
// share one adcclk/adc_data generator; outputs are collected per instance.
module tb_afe_capture;

   logic       clk = 1'b0;
   logic       adcclk = 1'b0;
   logic [7:0] adc_data = 8'h00;
   logic [2:0] ls = 3'b000;
   logic [2:0] rdy = 3'b111;
   logic       rst0_n = 1'b0, rst1_n = 1'b0, rst2_n = 1'b0;
   logic       busy0, busy1, busy2, ovf0, ovf1, ovf2;

   int         checks = 0;
   int         failures = 0;
   int         ph = 0;
   logic [7:0] n_idx = 8'h00;

   logic [16:0] q0[$], q1[$], q2[$];

   typedef struct { int t; logic [7:0] n; logic [16:0] exp; } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   afe_capture_if p0 ();
   afe_capture_if p1 ();
   afe_capture_if p2 ();
   assign p0.pix_ready = rdy[0];
   assign p1.pix_ready = rdy[1];
   assign p2.pix_ready = rdy[2];

   afe_capture #(.PIXELS(4), .PIPE_LAT(3), .SAMPLE_DLY(10)) u0 (
      .clk(clk), .rst_n(rst0_n), .adcclk(adcclk), .adc_data(adc_data),
      .line_start(ls[0]), .pix(p0), .busy(busy0), .overflow(ovf0));
   afe_capture #(.PIXELS(6), .PIPE_LAT(3), .SAMPLE_DLY(10)) u1 (
      .clk(clk), .rst_n(rst1_n), .adcclk(adcclk), .adc_data(adc_data),
      .line_start(ls[1]), .pix(p1), .busy(busy1), .overflow(ovf1));
   afe_capture #(.PIXELS(1), .PIPE_LAT(0), .SAMPLE_DLY(10)) u2 (
      .clk(clk), .rst_n(rst2_n), .adcclk(adcclk), .adc_data(adc_data),
      .line_start(ls[2]), .pix(p2), .busy(busy2), .overflow(ovf2));

   // Transfer log: accepted beats per instance as {last, data}.
   always @(negedge clk) begin
      if (p0.pix_valid && rdy[0]) q0.push_back({p0.pix_last, p0.pix_data});
      if (p1.pix_valid && rdy[1]) q1.push_back({p1.pix_last, p1.pix_data});
      if (p2.pix_valid && rdy[2]) q2.push_back({p2.pix_last, p2.pix_data});
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic int qsize(input int w);
      case (w)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic [16:0] qget(input int w, input int i);
      case (w)
         0:       return q0[i];
         1:       return q1[i];
         default: return q2[i];
      endcase
   endfunction

   // One clk step; inputs change 2 units after the rising edge.
   // adcclk: 20 clk high (high byte n), 20 clk low (low byte n+0x80).
   task automatic tick(input logic [2:0] lsm);
      @(posedge clk);
      #2;
      ls = lsm;
      ph = (ph == 39) ? 0 : ph + 1;
      if (ph == 0)  begin adcclk = 1'b1; adc_data = n_idx; end
      if (ph == 20) begin adcclk = 1'b0; adc_data = n_idx + 8'h80; end
      if (ph == 39) n_idx = n_idx + 8'd1;
   endtask

   // line_start lands on the last low clk, so the next adcclk period is n=0.
   task automatic start_line(input logic [2:0] m);
      int g = 0;
      while (ph != 38 && g < 100) begin tick(3'b000); g++; end
      tick(m);
      n_idx = 8'h00;
   endtask

   task automatic chk_tbl(input int t, input int w, input int base);
      int k = 0;
      foreach (tbl[i]) begin
         if (tbl[i].t == t) begin
            if (base + k < qsize(w))
               chk($sformatf("t%0d_n%0d_out%0d", t, tbl[i].n, k), 32'(qget(w, base + k)), 32'(tbl[i].exp));
            else
               chk($sformatf("t%0d_n%0d_out%0d_missing", t, tbl[i].n, k), 32'h0, 32'h1);
            k++;
         end
      end
      chk($sformatf("t%0d_count", t), 32'(qsize(w) - base), 32'(k));
   endtask

   task automatic chk_zero(input string nm, input logic v, input logic l,
                           input logic [15:0] d, input logic b, input logic o);
      chk({nm, "_valid"}, 32'(v), 0);
      chk({nm, "_last"},  32'(l), 0);
      chk({nm, "_data"},  32'(d), 0);
      chk({nm, "_busy"},  32'(b), 0);
      chk({nm, "_ovf"},   32'(o), 0);
   endtask

   initial begin
      int b, c, first, cnt, g;
      logic pb, seen;

      // {test, sample index, {last, data}}
      tbl.push_back('{1, 8'd3, 17'h00383});
      tbl.push_back('{1, 8'd4, 17'h00484});
      tbl.push_back('{1, 8'd5, 17'h00585});
      tbl.push_back('{1, 8'd6, 17'h10686});
      tbl.push_back('{2, 8'd3, 17'h00383});
      tbl.push_back('{2, 8'd4, 17'h00484});
      tbl.push_back('{2, 8'd5, 17'h00585});
      tbl.push_back('{2, 8'd6, 17'h00686});
      tbl.push_back('{3, 8'd3, 17'h00383});
      tbl.push_back('{3, 8'd4, 17'h00484});
      tbl.push_back('{3, 8'd3, 17'h00383});
      tbl.push_back('{3, 8'd4, 17'h00484});
      tbl.push_back('{3, 8'd5, 17'h00585});
      tbl.push_back('{3, 8'd6, 17'h10686});
      tbl.push_back('{4, 8'd7, 17'h00787});
      tbl.push_back('{4, 8'd8, 17'h00888});
      tbl.push_back('{4, 8'd9, 17'h00989});
      tbl.push_back('{4, 8'd10, 17'h10A8A});
      tbl.push_back('{6, 8'd0, 17'h10080});

      // Reset state
      repeat (5) tick(3'b000);
      chk_zero("rst_u0", p0.pix_valid, p0.pix_last, p0.pix_data, busy0, ovf0);
      chk_zero("rst_u1", p1.pix_valid, p1.pix_last, p1.pix_data, busy1, ovf1);
      rst0_n = 1'b1; rst1_n = 1'b1; rst2_n = 1'b1;
      repeat (50) tick(3'b000);
      chk_zero("idle_u2", p2.pix_valid, p2.pix_last, p2.pix_data, busy2, ovf2);

      // T1: basic line, latency to first pixel, busy drop with last
      b = q0.size();
      start_line(3'b001);
      first = 0; seen = 1'b0; pb = 1'b1;
      for (c = 1; c <= 340; c++) begin
         tick(3'b000);
         if (p0.pix_valid && first == 0) first = c;
         if (p0.pix_valid && p0.pix_last && !seen) begin
            seen = 1'b1;
            chk("t1_busy_at_last", 32'(busy0), 0);
            chk("t1_busy_before_last", 32'(pb), 1);
         end
         pb = busy0;
      end
      chk("t1_first_pixel_clk", 32'(first), 152);
      chk("t1_last_seen", 32'(seen), 1);
      chk_tbl(1, 0, b);

      // T2: backpressure fills FIFO, 5th/6th dropped, drain 4 without last
      rdy[1] = 1'b0;
      b = q1.size();
      start_line(3'b010);
      repeat (290) tick(3'b000);
      chk("t2_ovf_at_full", 32'(ovf1), 0);
      chk("t2_head_data", 32'(p1.pix_data), 32'h0383);
      chk("t2_head_valid", 32'(p1.pix_valid), 1);
      repeat (80) tick(3'b000);
      chk("t2_ovf_after_drop", 32'(ovf1), 1);
      chk("t2_busy_done", 32'(busy1), 0);
      rdy[1] = 1'b1;
      repeat (20) tick(3'b000);
      chk("t2_drained", 32'(p1.pix_valid), 0);
      chk_tbl(2, 1, b);

      // T3: restart after two pixels
      b = q0.size();
      start_line(3'b001);
      g = 0;
      while (q0.size() < b + 2 && g < 400) begin tick(3'b000); g++; end
      chk("t3_two_pixels_in_time", 32'(g < 400), 1);
      start_line(3'b001);
      tick(3'b000);
      chk("t3_busy_restart", 32'(busy0), 1);
      repeat (340) tick(3'b000);
      chk_tbl(3, 0, b);

      // T4: restart coincident with a low-byte latch in CAPTURE
      b = q0.size();
      start_line(3'b001);
      repeat (150) tick(3'b000);
      tick(3'b001);
      tick(3'b000);
      chk("t4_sample_killed", 32'(q0.size() - b), 0);
      chk("t4_valid_killed", 32'(p0.pix_valid), 0);
      chk("t4_busy", 32'(busy0), 1);
      repeat (320) tick(3'b000);
      chk_tbl(4, 0, b);

      // T5: async reset mid-line, 5 clk after a high-byte latch
      rdy[1] = 1'b0;
      start_line(3'b010);
      repeat (177) tick(3'b000);
      chk("t5_pre_valid", 32'(p1.pix_valid), 1);
      chk("t5_pre_ovf", 32'(ovf1), 1);
      chk("t5_pre_busy", 32'(busy1), 1);
      rst1_n = 1'b0;
      #1;
      chk_zero("t5_rst", p1.pix_valid, p1.pix_last, p1.pix_data, busy1, ovf1);
      repeat (3) tick(3'b000);
      rst1_n = 1'b1;
      rdy[1] = 1'b1;
      cnt = 0;
      b = q1.size();
      repeat (400) begin
         tick(3'b000);
         if (p1.pix_valid || busy1) cnt++;
      end
      chk("t5_quiet_after_rst", 32'(cnt), 0);
      chk("t5_no_transfers", 32'(q1.size() - b), 0);

      // T6: PIPE_LAT=0, PIXELS=1
      b = q2.size();
      start_line(3'b100);
      cnt = 0;
      repeat (120) begin
         tick(3'b000);
         if (busy2) cnt++;
      end
      chk("t6_busy_le41", 32'(cnt <= 41 && cnt > 0), 1);
      chk_tbl(6, 2, b);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
